// File: rtl/stream_pixel_packer_pkg.sv
// Shared types and sizing helpers for the camera pixel packer and its stream output stage.
package stream_pixel_packer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SOF,
    PACK
  } state_t;

  localparam int DROP_W = 16;

  function automatic int pack_ratio(input int wb_dw, input int pix_dw);
    return wb_dw / pix_dw;
  endfunction

  // A single-lane configuration still needs a 1-bit lane index to keep vectors legal.
  function automatic int lane_width(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/stream_out_reg.sv
// Single-entry valid/ready holding register; load_ok tells the producer whether a load will land.
module stream_out_reg #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  output logic [DW-1:0] data,
  output logic          valid,
  input  logic          ready,
  output logic          load_ok
);

  // Accepting a new word in the same cycle the old one leaves gives full throughput.
  assign load_ok = !valid || ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load && load_ok) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_pixel_packer.sv
// Packs a non-stallable camera pixel bus into wide stream words, gated to whole frames,
// dropping and counting words instead of stalling when the downstream stream is blocked.
module stream_pixel_packer
  import stream_pixel_packer_pkg::*;
#(
  parameter int PIX_DW      = 16,
  parameter int WB_DW       = 32,
  parameter int FRAME_WORDS = 163840,
  parameter int CNT_W       = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable_i,
  input  logic [PIX_DW-1:0] pix_data_i,
  input  logic              pix_valid_i,
  input  logic              pix_sof_i,
  output logic [WB_DW-1:0]  stream_m_data_o,
  output logic              stream_m_valid_o,
  input  logic              stream_m_ready_i,
  output logic              frame_done_o,
  output logic              overflow_o,
  output logic [15:0]       drop_cnt_o,
  output logic              busy_o
);

  localparam int RATIO  = pack_ratio(WB_DW, PIX_DW);
  localparam int LANE_W = lane_width(RATIO);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);
  localparam logic [CNT_W-1:0]  FRAME_LEN = CNT_W'(FRAME_WORDS);

  state_t              state, state_next;
  logic [LANE_W-1:0]   lane, wr_lane;
  logic [CNT_W-1:0]    word_cnt, cnt_base, cnt_next;
  logic [WB_DW-1:0]    pack_buf, word;
  logic                wr_en, resync, word_done, last_word, load_ok;
  logic                clear_stats, drop_word;
  logic                frame_done_q, overflow_q;
  logic [DROP_W-1:0]   drop_q, drop_next;
  logic [1:0]          drop_inc;
  logic [DROP_W:0]     drop_sum;

  // A SOF pixel always lands in lane 0 with the word count restarted, whether it opens a
  // frame or resynchronises one in progress.
  always_comb begin
    state_next  = state;
    wr_en       = 1'b0;
    wr_lane     = '0;
    cnt_base    = word_cnt;
    resync      = 1'b0;
    clear_stats = 1'b0;
    case (state)
      IDLE: begin
        if (enable_i) begin
          state_next  = WAIT_SOF;
          clear_stats = 1'b1;
        end
      end
      WAIT_SOF: begin
        if (!enable_i) begin
          state_next = IDLE;
        end else if (pix_valid_i && pix_sof_i) begin
          wr_en      = 1'b1;
          cnt_base   = '0;
          state_next = PACK;
        end
      end
      PACK: begin
        if (pix_valid_i) begin
          wr_en = 1'b1;
          if (pix_sof_i) begin
            resync   = 1'b1;
            cnt_base = '0;
          end else begin
            wr_lane = lane;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    word = pack_buf;
    if (wr_en) begin
      word[wr_lane*PIX_DW +: PIX_DW] = pix_data_i;
    end
    word_done = wr_en && (wr_lane == LAST_LANE);
    cnt_next  = cnt_base + 1'b1;
    last_word = word_done && (cnt_next == FRAME_LEN);
    if (last_word) begin
      state_next = enable_i ? WAIT_SOF : IDLE;
    end
    drop_word = word_done && !load_ok;
  end

  // Both a discarded partial word and a blocked complete word count as drops; saturate at all-ones.
  always_comb begin
    drop_inc  = {1'b0, resync} + {1'b0, drop_word};
    drop_sum  = {1'b0, drop_q} + {{(DROP_W - 1){1'b0}}, drop_inc};
    drop_next = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
  end

  // frame_done follows camera timing, so it pulses even when the final word itself is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      lane         <= '0;
      word_cnt     <= '0;
      pack_buf     <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      drop_q       <= '0;
    end else begin
      state        <= state_next;
      frame_done_q <= last_word;
      if (wr_en) begin
        pack_buf <= word;
        lane     <= word_done ? '0 : wr_lane + 1'b1;
        word_cnt <= word_done ? (last_word ? '0 : cnt_next) : cnt_base;
      end
      if (clear_stats) begin
        overflow_q <= 1'b0;
        drop_q     <= '0;
      end else begin
        if (resync || drop_word) begin
          overflow_q <= 1'b1;
        end
        drop_q <= drop_next;
      end
    end
  end

  stream_out_reg #(
    .DW(WB_DW)
  ) u_out_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (word_done),
    .load_data(word),
    .data     (stream_m_data_o),
    .valid    (stream_m_valid_o),
    .ready    (stream_m_ready_i),
    .load_ok  (load_ok)
  );

  assign frame_done_o = frame_done_q;
  assign overflow_o   = overflow_q;
  assign drop_cnt_o   = drop_q;
  assign busy_o       = (state == PACK) || stream_m_valid_o;

endmodule

// File: tb/tb_stream_pixel_packer.sv
// Bench for stream_pixel_packer with a 4-word frame: vector table for normal packing,
// hand-written sequences for overflow, resync, enable drop and reset; words checked by scoreboard.
module tb_stream_pixel_packer;

  localparam int PIX_DW      = 16;
  localparam int WB_DW       = 32;
  localparam int FRAME_WORDS = 4;
  localparam int CNT_W       = 18;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic [PIX_DW-1:0] pix_data;
  logic              pix_valid;
  logic              pix_sof;
  logic              ready;
  logic [WB_DW-1:0]  stream_m_data_o;
  logic              stream_m_valid_o;
  logic              frame_done_o;
  logic              overflow_o;
  logic [15:0]       drop_cnt_o;
  logic              busy_o;

  int tests_run  = 0;
  int fail_count = 0;
  logic [WB_DW-1:0] exp_q[$];

  typedef struct {
    logic        en;
    logic        v;
    logic        sof;
    logic [15:0] pix;
    logic        rdy;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic        exp_fd;
    logic        exp_busy;
  } vec_t;

  vec_t vecs[12];

  always #5 clk = ~clk;

  stream_pixel_packer #(
    .PIX_DW     (PIX_DW),
    .WB_DW      (WB_DW),
    .FRAME_WORDS(FRAME_WORDS),
    .CNT_W      (CNT_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .enable_i        (enable),
    .pix_data_i      (pix_data),
    .pix_valid_i     (pix_valid),
    .pix_sof_i       (pix_sof),
    .stream_m_data_o (stream_m_data_o),
    .stream_m_valid_o(stream_m_valid_o),
    .stream_m_ready_i(ready),
    .frame_done_o    (frame_done_o),
    .overflow_o      (overflow_o),
    .drop_cnt_o      (drop_cnt_o),
    .busy_o          (busy_o)
  );

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic en, input logic v, input logic sof,
                                input logic [15:0] pix, input logic rdy);
    enable    = en;
    pix_valid = v;
    pix_sof   = sof;
    pix_data  = pix;
    ready     = rdy;
  endtask

  task automatic step(input logic en, input logic v, input logic sof,
                      input logic [15:0] pix, input logic rdy);
    apply_stimulus(en, v, sof, pix, rdy);
    @(posedge clk);
    #1;
  endtask

  // A transfer happens at the next rising edge whenever valid and ready are both high mid-cycle.
  always @(negedge clk) begin
    if (stream_m_valid_o && ready) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        fail_count++;
        $display("[TB] FAIL unexpected_word: got %h, expected no word", stream_m_data_o);
      end else begin
        check_output("scoreboard_word", stream_m_data_o, exp_q.pop_front());
      end
    end
  end

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 32'h00000000, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 16'hAAAA, 1'b1, 1'b0, 32'h00000000, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 16'h1111, 1'b1, 1'b0, 32'h00000000, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 16'h2222, 1'b1, 1'b1, 32'h22221111, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 16'h3333, 1'b1, 1'b0, 32'h00000000, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 16'h4444, 1'b1, 1'b1, 32'h44443333, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 16'h5555, 1'b1, 1'b0, 32'h00000000, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 16'h6666, 1'b1, 1'b1, 32'h66665555, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 16'h7777, 1'b1, 1'b0, 32'h00000000, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 16'h8888, 1'b1, 1'b1, 32'h88887777, 1'b1, 1'b1};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 16'h9999, 1'b1, 1'b0, 32'h00000000, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 16'hAAAA, 1'b1, 1'b0, 32'h00000000, 1'b0, 1'b0};

    rst = 1'b1;
    apply_stimulus(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    @(posedge clk);
    #1;
    check_output("reset_valid", stream_m_valid_o, 0);
    check_output("reset_data", stream_m_data_o, 0);
    check_output("reset_frame_done", frame_done_o, 0);
    check_output("reset_overflow", overflow_o, 0);
    check_output("reset_drop_cnt", drop_cnt_o, 0);
    check_output("reset_busy", busy_o, 0);
    rst = 1'b0;

    // Normal packing, one full frame, then non-SOF pixels that must be ignored.
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].exp_valid) exp_q.push_back(vecs[i].exp_data);
      step(vecs[i].en, vecs[i].v, vecs[i].sof, vecs[i].pix, vecs[i].rdy);
      check_output($sformatf("vec%0d_valid", i), stream_m_valid_o, vecs[i].exp_valid);
      if (vecs[i].exp_valid) check_output($sformatf("vec%0d_data", i), stream_m_data_o, vecs[i].exp_data);
      check_output($sformatf("vec%0d_frame_done", i), frame_done_o, vecs[i].exp_fd);
      check_output($sformatf("vec%0d_busy", i), busy_o, vecs[i].exp_busy);
    end
    check_output("vec_drop_cnt", drop_cnt_o, 0);

    // Blocked downstream: first word held, next two complete words dropped.
    step(1, 1, 1, 16'h0101, 0);
    exp_q.push_back(32'h02020101);
    step(1, 1, 0, 16'h0202, 0);
    check_output("hold_valid", stream_m_valid_o, 1);
    step(1, 1, 0, 16'h0303, 0);
    check_output("hold_data_1", stream_m_data_o, 32'h02020101);
    step(1, 1, 0, 16'h0404, 0);
    check_output("hold_data_2", stream_m_data_o, 32'h02020101);
    step(1, 1, 0, 16'h0505, 0);
    step(1, 1, 0, 16'h0606, 0);
    check_output("hold_data_3", stream_m_data_o, 32'h02020101);
    check_output("hold_valid_3", stream_m_valid_o, 1);
    step(1, 1, 0, 16'h0707, 1);
    check_output("ovf_frame_done_early", frame_done_o, 0);
    exp_q.push_back(32'h08080707);
    step(1, 1, 0, 16'h0808, 1);
    check_output("ovf_frame_done", frame_done_o, 1);
    check_output("ovf_last_data", stream_m_data_o, 32'h08080707);
    check_output("ovf_drop_cnt", drop_cnt_o, 2);
    check_output("ovf_overflow", overflow_o, 1);
    step(1, 0, 0, 16'h0000, 1);
    check_output("ovf_frame_done_after", frame_done_o, 0);

    // Going through IDLE clears the statistics; then a mid-frame SOF resync.
    step(0, 0, 0, 16'h0000, 1);
    step(1, 0, 0, 16'h0000, 1);
    check_output("clear_drop_cnt", drop_cnt_o, 0);
    check_output("clear_overflow", overflow_o, 0);
    step(1, 1, 1, 16'h1010, 1);
    exp_q.push_back(32'h20201010);
    step(1, 1, 0, 16'h2020, 1);
    step(1, 1, 0, 16'h3030, 1);
    step(1, 1, 1, 16'h4040, 1);
    check_output("resync_drop_cnt", drop_cnt_o, 1);
    check_output("resync_overflow", overflow_o, 1);
    check_output("resync_valid", stream_m_valid_o, 0);
    exp_q.push_back(32'h50504040);
    step(1, 1, 0, 16'h5050, 1);
    check_output("resync_data", stream_m_data_o, 32'h50504040);
    check_output("resync_no_frame_done", frame_done_o, 0);
    step(1, 1, 0, 16'h6060, 1);
    exp_q.push_back(32'h70706060);
    step(1, 1, 0, 16'h7070, 1);
    step(1, 1, 0, 16'h8080, 1);
    exp_q.push_back(32'h90908080);
    step(1, 1, 0, 16'h9090, 1);
    check_output("resync_frame_done_3rd", frame_done_o, 0);
    step(1, 1, 0, 16'hA0A0, 1);
    exp_q.push_back(32'hB0B0A0A0);
    step(1, 1, 0, 16'hB0B0, 1);
    check_output("resync_frame_done_4th", frame_done_o, 1);

    // enable drops mid-frame: the frame still completes, then SOF is ignored.
    step(1, 1, 1, 16'hD1D1, 1);
    exp_q.push_back(32'hD2D2D1D1);
    step(1, 1, 0, 16'hD2D2, 1);
    step(0, 1, 0, 16'hD3D3, 1);
    exp_q.push_back(32'hD4D4D3D3);
    step(0, 1, 0, 16'hD4D4, 1);
    check_output("endrop_busy", busy_o, 1);
    step(0, 1, 0, 16'hD5D5, 1);
    exp_q.push_back(32'hD6D6D5D5);
    step(0, 1, 0, 16'hD6D6, 1);
    step(0, 1, 0, 16'hD7D7, 1);
    exp_q.push_back(32'hD8D8D7D7);
    step(0, 1, 0, 16'hD8D8, 1);
    check_output("endrop_frame_done", frame_done_o, 1);
    step(0, 0, 0, 16'h0000, 1);
    check_output("endrop_idle_busy", busy_o, 0);
    step(0, 1, 1, 16'hE1E1, 1);
    step(0, 1, 0, 16'hE2E2, 1);
    check_output("endrop_sof_ignored", stream_m_valid_o, 0);
    check_output("endrop_busy_after_sof", busy_o, 0);
    check_output("endrop_drop_kept", drop_cnt_o, 1);
    step(1, 0, 0, 16'h0000, 1);
    check_output("endrop_reenable_clear", drop_cnt_o, 0);

    // Synchronous reset while a word is held and a drop has been counted.
    step(1, 1, 1, 16'hC1C1, 0);
    step(1, 1, 0, 16'hC2C2, 0);
    check_output("rst_pre_valid", stream_m_valid_o, 1);
    step(1, 1, 0, 16'hC3C3, 0);
    step(1, 1, 0, 16'hC4C4, 0);
    check_output("rst_pre_drop", drop_cnt_o, 1);
    rst = 1'b1;
    step(0, 1, 0, 16'hC5C5, 0);
    rst = 1'b0;
    check_output("rst_valid", stream_m_valid_o, 0);
    check_output("rst_data", stream_m_data_o, 0);
    check_output("rst_drop_cnt", drop_cnt_o, 0);
    check_output("rst_overflow", overflow_o, 0);
    check_output("rst_busy", busy_o, 0);
    step(0, 1, 1, 16'hF1F1, 1);
    step(0, 1, 0, 16'hF2F2, 1);
    check_output("rst_idle_valid", stream_m_valid_o, 0);

    repeat (3) step(0, 0, 0, 16'h0000, 1);
    check_output("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule
